// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_subtractor_pkg;

  // Control FSM states: waiting for operands, shifting bits, holding result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Width of the bit counter that walks 0..width-1
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module full_subtractor_bit
  import serial_subtractor_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // Difference bit and borrow-out of a single bit position
  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, Result = A - B - Bin, LSB first; optional clamp via SERIAL_SUBTRACTOR_SATURATE_EN.
// Latency: operands accepted at edge k give out_valid after edge k+WIDTH; one op per WIDTH+1 cycles at best.
// Backpressure: in_ready only in IDLE; DONE holds result and flags stable until out_ready.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Borrow,
  output logic             Zero,
  output logic             Overflow
);

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_bit;
  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] diff_full;
  logic             ovf_raw;
  logic [WIDTH-1:0] res_final;

  full_subtractor_bit u_fsb (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .bin_i  (br_q),
    .d_o    (bit_d),
    .bout_o (bit_bout)
  );

  assign accept   = in_valid && in_ready;
  assign last_bit = (state_q == RUN) && (cnt_q == LAST_CNT);

  // Final difference with this cycle's bit landing in the MSB; overflow from sign bits only
  always_comb begin
    diff_full = {bit_d, diff_sr_q[WIDTH-1:1]};
    ovf_raw   = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
    if (ovf_raw) begin
      res_final = a_msb_q ? MOST_NEG : MOST_POS;
    end else begin
      res_final = diff_full;
    end
`else
    res_final = diff_full;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake signals decoded from state alone
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state: load on accept, shift one bit per RUN cycle, publish on the last bit
  always_comb begin
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    br_d      = br_q;
    cnt_d     = cnt_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    result_d  = result_q;
    borrow_d  = borrow_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    if (accept) begin
      a_sr_d    = A;
      b_sr_d    = B;
      diff_sr_d = '0;
      br_d      = Bin;
      cnt_d     = '0;
      a_msb_d   = A[WIDTH-1];
      b_msb_d   = B[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sr_d    = a_sr_q >> 1;
      b_sr_d    = b_sr_q >> 1;
      diff_sr_d = diff_full;
      br_d      = bit_bout;
      cnt_d     = last_bit ? '0 : cnt_q + CW'(1);
      if (last_bit) begin
        result_d = res_final;
        borrow_d = bit_bout;
        zero_d   = ~|res_final;
        ovf_d    = ovf_raw;
      end
    end
  end

  // Datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      br_q      <= 1'b0;
      cnt_q     <= '0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      result_q  <= '0;
      borrow_q  <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      br_q      <= br_d;
      cnt_q     <= cnt_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      result_q  <= result_d;
      borrow_q  <= borrow_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
    end
  end

  assign Result   = result_q;
  assign Borrow   = borrow_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule : serial_subtractor

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial two's-complement subtractor. Computes Result = A - B - Bin one bit per clock, LSB first.
- Reports the flags Borrow, Zero and Overflow.
- Inverse companion to the team's combinational adder, for area-constrained datapaths that tolerate WIDTH-cycle latency.
- Sits behind a valid/ready operand port and in front of a valid/ready result port.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- Result  output  WIDTH  difference.
- Borrow  output  1  unsigned borrow-out (1 when A < B + Bin as unsigned).
- Zero  output  1  Result == 0.
- Overflow  output  1  signed overflow.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (async assert, sync to clk on deassert internally not required): state=IDLE; Result, Borrow, Zero, Overflow, out_valid = 0; internal shift registers, bit counter and borrow FF = 0.
- in_ready = (state == IDLE), combinational from state only.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On in_valid && in_ready: latch A, B into shift regs, borrow FF <= Bin, count <= 0, capture A[WIDTH-1] and B[WIDTH-1] for overflow, go RUN.
  - Otherwise stay.
- RUN: each cycle feeds shift-reg LSBs a_i, b_i and borrow FF into a 1-bit full subtractor:
  - d = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Shift d into the result register MSB-side; borrow FF <= br'; count++.
  - When count == WIDTH-1, go DONE and update outputs that edge.
- DONE: out_valid = 1; Result, Borrow, Zero, Overflow stable.
  - On out_ready: out_valid <= 0 next edge, go IDLE.
  - No new operand accepted in the DONE cycle.
- Latency: accept at edge k → out_valid high after edge k+WIDTH. Throughput: one operation per WIDTH+1 cycles minimum.
- Flags:
  - Borrow = final br.
  - Zero = ~|Result.
  - Overflow = (A_msb != B_msb) && (Result[WIDTH-1] != A_msb).
  - Bin does not participate in the overflow rule.
- Outputs hold the last result after returning to IDLE; out_valid alone qualifies them.
- Backpressure: out_ready low in DONE holds indefinitely with all outputs stable.
- in_valid asserted during RUN/DONE is ignored and not queued. Operand changes after acceptance have no effect.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the in-flight operation is discarded.
- Wrap-around: Result is modulo 2^WIDTH; borrow beyond the MSB appears only on Borrow.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_SATURATE_EN.
- Defined: when Overflow = 1, Result is clamped:
  - A_msb = 1 → most-negative value (1 followed by zeros).
  - A_msb = 0 → most-positive value (0 followed by ones).
  - Borrow and Overflow are unchanged; Zero is computed on the clamped Result.
  - Clamp is applied at the RUN→DONE edge; latency is unchanged.
- Undefined: Result wraps as specified above.

Decomposition:
- Package serial_subtractor_pkg holds:
  - State enum sub_state_t {IDLE, RUN, DONE}.
  - Function for count width ($clog2(WIDTH)).
- One sub-module: full_subtractor_bit, combinational (a, b, bin → d, bout), instantiated once in the RUN datapath.

Test Plan:
- WIDTH=4, A=5, B=3, Bin=0 → after 4 cycles: Result=2, Borrow=0, Zero=0, Overflow=0; in_ready low for cycles 1..5.
- A=3, B=5, Bin=0 → Result=4'hE, Borrow=1, Overflow=0. Then A=4, B=4 → Result=0, Zero=1, Borrow=0.
- A=4'h8, B=1, Bin=0 → Result=4'h7, Overflow=1, Borrow=0. With SERIAL_SUBTRACTOR_SATURATE_EN: Result=4'h8, Zero=0.
- A=7, B=4'hF, Bin=1 → Result=4'h7, Borrow=1, Overflow=0. A=7, B=4'hF, Bin=0 → Result=4'h8, Overflow=1; saturated build gives 4'h7.
- Backpressure: out_ready held low 10 cycles → out_valid and outputs stable throughout; in_valid pulses ignored; release → IDLE next edge, in_ready=1.
- Assert rst_n=0 at RUN cycle 2 → all outputs 0 immediately, state IDLE. A fresh operation afterwards completes correctly.
